// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, FSM encoding and range helper for the PC fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_unit_pkg;
  localparam int N  = 32;  // instruction / next-PC width
  localparam int Pb = 8;   // implemented PC width (word address)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  // A next-PC value is only usable if nothing above the implemented PC bits is set.
  function automatic logic pc_in_range(input logic [N-1:0] v);
    return v[N-1:Pb] == '0;
  endfunction
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clearable up-counter raising tc once TIMEOUT-1 has been reached.
// Latency: count updates one cycle after en; tc is combinational from the count.
// Backpressure: none; the count holds at the terminal value until cleared.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count waiting cycles; clear has priority, saturate at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == LAST);
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: fetches imem[pc] over req/ack, presents it to decode, loads next_pc on accept.
// Latency: ack -> instr_valid next cycle; decode accept -> next imem_req next cycle (2 cycles/instr best case).
// Backpressure: instr_out held while dec_ready=0; memory stalls bounded by TIMEOUT, then sticky error.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [Pb-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  output logic          imem_req,
  output logic [Pb-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [N-1:0]  imem_rdata,
  output logic [N-1:0]  instr_out,
  output logic          instr_valid,
  input  logic          dec_ready,
  output logic [Pb-1:0] pc_out,
  input  logic [N-1:0]  next_pc,
  output logic          fetch_err
);
  fetch_state_t  state;
  logic [Pb-1:0] pc;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;

  // The timeout only runs while a fetch is outstanding and restarts on every ack.
  assign cnt_en  = (state == FETCH) && !imem_ack;
  assign cnt_clr = (state != FETCH) || imem_ack;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Main FSM plus PC, instruction latch and sticky error; ack beats timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr_out <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_out <= imem_rdata;
            state     <= VALID;
          end else if (cnt_tc) begin
            fetch_err <= 1'b1;
            state     <= ERR;
          end
        end
        VALID: begin
          if (dec_ready) begin
            if (pc_in_range(next_pc)) begin
              pc    <= next_pc[Pb-1:0];
              state <= halt ? IDLE : FETCH;
            end else begin
              // Out-of-range target (including wrap past the top word): keep pc for debug.
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end
        end
        ERR: begin
          fetch_err <= 1'b1;
        end
        default: begin
          fetch_err <= 1'b1;
          state     <= ERR;
        end
      endcase
    end
  end

  // Request and valid decode straight from state so an async reset drops them at once.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign imem_addr   = pc;
  assign pc_out      = pc;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench: directed boundary cases followed by randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: randomized memory ack delay and decode readiness.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam int TMO = 16;

  logic          clk;
  logic          rst_n;
  logic          halt;
  logic          imem_req;
  logic [Pb-1:0] imem_addr;
  logic          imem_ack;
  logic [N-1:0]  imem_rdata;
  logic [N-1:0]  instr_out;
  logic          instr_valid;
  logic          dec_ready;
  logic [Pb-1:0] pc_out;
  logic [N-1:0]  next_pc;
  logic          fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.RESET_PC(8'd0), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .pc_out      (pc_out),
    .next_pc     (next_pc),
    .fetch_err   (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory contents model: a fixed, address-dependent word.
  function automatic logic [N-1:0] mem_word(input logic [Pb-1:0] a);
    return {a, ~a, a ^ 8'h5a, 8'hc3};
  endfunction

  logic [Pb-1:0] exp_pc;
  logic [N-1:0]  np;
  int w, delay, hold, n_instr;
  logic pend_req, pend_valid;

  initial begin
    rst_n = 1'b0; halt = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    dec_ready = 1'b0; next_pc = '0;
    #12;
    check("rst_req",   N'(imem_req), 0);
    check("rst_valid", N'(instr_valid), 0);
    check("rst_instr", instr_out, 0);
    check("rst_err",   N'(fetch_err), 0);
    check("rst_pc",    N'(pc_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // halt keeps the unit idle
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_idle_req", N'(imem_req), 0);
    end
    halt = 1'b0;
    step();
    check("first_req", N'(imem_req), 1);
    check("first_addr", N'(imem_addr), 0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hdead_beef;
    check("first_valid", N'(instr_valid), 1);
    check("first_instr", instr_out, 32'h2008_0005);
    check("valid_no_req", N'(imem_req), 0);

    // decode stalls three cycles; stray ack ignored
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr_out, 32'h2008_0005);
      check("stall_valid", N'(instr_valid), 1);
    end
    imem_ack = 1'b0;
    dec_ready = 1'b1; next_pc = 32'd1;
    step();
    dec_ready = 1'b0;
    check("seq_pc", N'(pc_out), 1);
    check("seq_req", N'(imem_req), 1);

    // jump to 40
    imem_ack = 1'b1; imem_rdata = 32'h0800_0028;
    step();
    imem_ack = 1'b0;
    check("jmp_hold_pc", N'(pc_out), 1);
    dec_ready = 1'b1; next_pc = 32'd40;
    step();
    dec_ready = 1'b0;
    check("jmp_addr", N'(imem_addr), 40);
    check("jmp_req", N'(imem_req), 1);

    // no ack: error exactly TMO cycles after FETCH entry
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k < TMO) check("tmo_early_err", N'(fetch_err), 0);
    end
    check("tmo_err", N'(fetch_err), 1);
    check("tmo_req", N'(imem_req), 0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky", N'(fetch_err), 1);
      check("err_no_valid", N'(instr_valid), 0);
      check("err_no_req", N'(imem_req), 0);
    end
    imem_ack = 1'b0;

    // recover with reset, fetch to pc=7, then pulse reset between edges
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rec_req", N'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = mem_word(8'd0);
    step();
    imem_ack = 1'b0;
    dec_ready = 1'b1; next_pc = 32'd7;
    step();
    dec_ready = 1'b0;
    check("pre_pulse_addr", N'(imem_addr), 7);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", N'(imem_req), 0);
    check("async_pc", N'(pc_out), 0);
    #1 rst_n = 1'b1;
    step();
    check("restart_req", N'(imem_req), 1);
    check("restart_pc", N'(pc_out), 0);

    // overflow at the top word
    imem_ack = 1'b1; imem_rdata = mem_word(8'd0);
    step();
    imem_ack = 1'b0;
    dec_ready = 1'b1; next_pc = 32'd255;
    step();
    dec_ready = 1'b0;
    check("top_addr", N'(imem_addr), 255);
    imem_ack = 1'b1; imem_rdata = mem_word(8'd255);
    step();
    imem_ack = 1'b0;
    dec_ready = 1'b1; next_pc = 32'd256;
    step();
    dec_ready = 1'b0;
    check("ovf_err", N'(fetch_err), 1);
    check("ovf_pc", N'(pc_out), 255);
    check("ovf_req", N'(imem_req), 0);
    check("ovf_valid", N'(instr_valid), 0);

    // randomized traffic against a transaction-level model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    halt = 1'b0;
    exp_pc = 8'd0; w = 0; delay = 0; hold = 0; n_instr = 0;
    pend_req = 1'b0; pend_valid = 1'b0;
    step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_no_err", N'(fetch_err), 0);
      if (pend_req)   check("rnd_req_after_hs", N'(imem_req), 1);
      if (pend_valid) check("rnd_valid_after_ack", N'(instr_valid), 1);
      pend_req = 1'b0; pend_valid = 1'b0;
      if (instr_valid) check("rnd_instr", instr_out, mem_word(exp_pc));
      imem_ack = 1'b0; dec_ready = 1'b0; next_pc = $urandom;
      imem_rdata = $urandom;
      if (hold > 0) begin
        check("rnd_halt_idle", N'(imem_req | instr_valid), 0);
        hold--;
        if (hold == 0) begin
          halt = 1'b0;
          pend_req = 1'b1;
        end
      end else if (imem_req) begin
        check("rnd_addr", N'(imem_addr), N'(exp_pc));
        if (w >= delay) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          w = 0;
          delay = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
          pend_valid = 1'b1;
        end else begin
          w++;
        end
      end else if (instr_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          dec_ready = 1'b1;
          if (exp_pc != 8'd255 && $urandom_range(0, 9) < 7) np = N'(exp_pc) + 1;
          else np = N'($urandom_range(0, 255));
          next_pc = np;
          exp_pc = np[Pb-1:0];
          n_instr++;
          if ($urandom_range(0, 5) == 0) begin
            halt = 1'b1;
            hold = $urandom_range(1, 3);
          end else begin
            pend_req = 1'b1;
          end
        end
        if ($urandom_range(0, 3) == 0) imem_ack = 1'b1;
      end
      step();
    end
    check("rnd_instr_count", N'(n_instr >= 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
